// File: rtl/square_decode.sv
// Square-wave tone decoder: recovers half_period and high-level volume from a sample stream.
// Optional no-edge timeout is enabled by defining SQUARE_DECODE_TIMEOUT_EN.
module square_decode #(
   parameter logic [20:0] TIMEOUT = 21'h1FFFFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [15:0] sample,
   output logic [20:0] half_period,
   output logic [15:0] volume,
   output logic        locked,
   output logic        valid,
   output logic        timeout,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_SEEK, S_MEAS, S_LOCK} state_t;

   localparam logic [20:0] CNT_MAX = 21'h1FFFFF;

   state_t      state_q, state_d;
   logic [15:0] sample_q;
   logic        lvl_q;
   logic [20:0] cnt_q, cnt_d;
   logic [20:0] m_prev_q, m_prev_d;
   logic        m_seen_q, m_seen_d;
   logic [15:0] vol_cap_q, vol_cap_d;
   logic [15:0] vol_prev_q, vol_prev_d;
   logic        vol_seen_q, vol_seen_d;
   logic [20:0] half_period_q, half_period_d;
   logic [15:0] volume_q, volume_d;
   logic        locked_q, locked_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;

   logic level, edge_det, rise, fall, vol_match, timeout_hit, clear_all;

   assign level     = (sample_q != 16'd0);
   assign edge_det  = (level != lvl_q);
   assign rise      = edge_det & level;
   assign fall      = edge_det & ~level;
   // Volume is only meaningful on falling edges, once a high phase has been captured.
   assign vol_match = ~fall | ~vol_seen_q | (vol_cap_q == vol_prev_q);

`ifdef SQUARE_DECODE_TIMEOUT_EN
   assign timeout_hit = (state_q != S_IDLE) && !edge_det && (cnt_q == TIMEOUT);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = edge_det ? 21'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 21'd1);
      m_prev_d      = m_prev_q;
      m_seen_d      = m_seen_q;
      vol_cap_d     = rise ? sample_q : vol_cap_q;
      vol_prev_d    = vol_prev_q;
      vol_seen_d    = vol_seen_q;
      half_period_d = half_period_q;
      volume_d      = volume_q;
      locked_d      = locked_q;
      valid_d       = 1'b0;
      timeout_d     = edge_det ? 1'b0 : timeout_q;
      clear_all     = 1'b0;

      if (fall && (state_q == S_MEAS || state_q == S_LOCK)) begin
         vol_prev_d = vol_cap_q;
         vol_seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            clear_all = 1'b1;
            state_d   = S_SEEK;
         end
         S_SEEK: begin
            if (edge_det) state_d = S_MEAS;
         end
         S_MEAS: begin
            if (edge_det) begin
               m_prev_d = cnt_q;
               m_seen_d = 1'b1;
               if (m_seen_q && cnt_q == m_prev_q && vol_match) begin
                  state_d       = S_LOCK;
                  half_period_d = cnt_q;
                  volume_d      = vol_cap_q;
                  locked_d      = 1'b1;
                  valid_d       = 1'b1;
               end
            end
         end
         S_LOCK: begin
            if (edge_det) begin
               if (cnt_q == half_period_q && vol_match) begin
                  valid_d = 1'b1;
               end else begin
                  state_d  = S_MEAS;
                  locked_d = 1'b0;
                  m_prev_d = cnt_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout_hit) begin
         state_d       = S_SEEK;
         half_period_d = 21'd0;
         volume_d      = 16'd0;
         locked_d      = 1'b0;
         valid_d       = 1'b0;
         timeout_d     = 1'b1;
         m_seen_d      = 1'b0;
         vol_seen_d    = 1'b0;
      end

      // Dropping enable overrides any edge seen in the same clock.
      if (clear_all || !enable) begin
         cnt_d         = 21'd0;
         m_prev_d      = 21'd0;
         m_seen_d      = 1'b0;
         vol_cap_d     = 16'd0;
         vol_prev_d    = 16'd0;
         vol_seen_d    = 1'b0;
         half_period_d = 21'd0;
         volume_d      = 16'd0;
         locked_d      = 1'b0;
         valid_d       = 1'b0;
         timeout_d     = 1'b0;
      end
      if (!enable) state_d = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         sample_q      <= 16'd0;
         lvl_q         <= 1'b0;
         cnt_q         <= 21'd0;
         m_prev_q      <= 21'd0;
         m_seen_q      <= 1'b0;
         vol_cap_q     <= 16'd0;
         vol_prev_q    <= 16'd0;
         vol_seen_q    <= 1'b0;
         half_period_q <= 21'd0;
         volume_q      <= 16'd0;
         locked_q      <= 1'b0;
         valid_q       <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sample_q      <= sample;
         lvl_q         <= level;
         cnt_q         <= cnt_d;
         m_prev_q      <= m_prev_d;
         m_seen_q      <= m_seen_d;
         vol_cap_q     <= vol_cap_d;
         vol_prev_q    <= vol_prev_d;
         vol_seen_q    <= vol_seen_d;
         half_period_q <= half_period_d;
         volume_q      <= volume_d;
         locked_q      <= locked_d;
         valid_q       <= valid_d;
         timeout_q     <= timeout_d;
      end
   end

   assign half_period = half_period_q;
   assign volume      = volume_q;
   assign locked      = locked_q;
   assign valid       = valid_q;
   assign timeout     = timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_square_decode.sv
// Directed bench for square_decode; the timeout section runs only with SQUARE_DECODE_TIMEOUT_EN.
module tb_square_decode;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] sample = 16'd0;
   logic [20:0] half_period;
   logic [15:0] volume;
   logic        locked, valid, timeout;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail = 0;
   int valid_cnt = 0;
   int bad_valid = 0;
   int v0;

   square_decode #(.TIMEOUT(21'd100)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .sample(sample),
      .half_period(half_period), .volume(volume), .locked(locked),
      .valid(valid), .timeout(timeout), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   // Pulse monitor, sampled well after the active edge.
   always begin
      @(posedge clock);
      #2;
      if (valid) valid_cnt++;
      if (valid && !locked) bad_valid++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic [15:0] s);
      @(negedge clock);
      sample = s;
   endtask

   task automatic phase(input logic [15:0] s, input int n);
      repeat (n) tick(s);
   endtask

   initial begin
      // Reset with a toggling input
      enable = 1'b1;
      for (int i = 0; i < 6; i++) tick(i[0] ? 16'h4000 : 16'h0000);
      check_eq("rst_half_period", 32'(half_period), 32'd0);
      check_eq("rst_volume", 32'(volume), 32'd0);
      check_eq("rst_locked", 32'(locked), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      reset_n = 1'b1;

      // Disabled decoder never locks
      enable = 1'b0;
      for (int i = 0; i < 20; i++) tick(i[0] ? 16'h4000 : 16'h0000);
      check_eq("en0_locked", 32'(locked), 32'd0);
      check_eq("en0_valid_cnt", 32'(valid_cnt), 32'd0);

      // Basic lock at H=3, volume 4000
      enable = 1'b1;
      phase(16'h0000, 5);
      phase(16'h4000, 4);
      phase(16'h0000, 4);
      check_eq("pre_lock", 32'(locked), 32'd0);
      phase(16'h4000, 4);
      check_eq("lock_locked", 32'(locked), 32'd1);
      check_eq("lock_half_period", 32'(half_period), 32'd3);
      check_eq("lock_volume", 32'(volume), 32'h4000);
      check_eq("lock_valid_cnt", 32'(valid_cnt), 32'd1);
      check_eq("lock_state", 32'(dbg_state), 32'd3);
      phase(16'h0000, 4);
      phase(16'h4000, 4);
      phase(16'h0000, 4);
      check_eq("pulse_count", 32'(valid_cnt), 32'd4);

      // Latency: edge sample in cycle N, valid in N+2, one clock wide
      tick(16'h4000);
      tick(16'h4000);
      check_eq("lat_n1", 32'(valid), 32'd0);
      tick(16'h4000);
      check_eq("lat_n2", 32'(valid), 32'd1);
      tick(16'h4000);
      check_eq("lat_width", 32'(valid), 32'd0);

      // Period change 3 -> 7
      phase(16'h0000, 8);
      phase(16'h4000, 8);
      check_eq("per_drop", 32'(locked), 32'd0);
      check_eq("per_hold_hp", 32'(half_period), 32'd3);
      check_eq("per_hold_vol", 32'(volume), 32'h4000);
      phase(16'h0000, 8);
      check_eq("per_relock", 32'(locked), 32'd1);
      check_eq("per_relock_hp", 32'(half_period), 32'd7);

      // Volume change 4000 -> 1000
      phase(16'h1000, 8);
      check_eq("vol_rise_locked", 32'(locked), 32'd1);
      check_eq("vol_rise_vol", 32'(volume), 32'h4000);
      phase(16'h0000, 8);
      check_eq("vol_drop", 32'(locked), 32'd0);
      check_eq("vol_drop_hold", 32'(volume), 32'h4000);
      phase(16'h1000, 8);
      check_eq("vol_relock", 32'(locked), 32'd1);
      check_eq("vol_relock_vol", 32'(volume), 32'h1000);
      check_eq("vol_relock_hp", 32'(half_period), 32'd7);

      // Enable drop mid-phase clears outputs one clock later
      phase(16'h0000, 3);
      check_eq("en_pre_locked", 32'(locked), 32'd1);
      enable = 1'b0;
      tick(16'h0000);
      check_eq("en_drop_locked", 32'(locked), 32'd0);
      check_eq("en_drop_hp", 32'(half_period), 32'd0);
      check_eq("en_drop_vol", 32'(volume), 32'd0);

      // Minimum phase: alternate every clock
      enable = 1'b1;
      phase(16'h0000, 3);
      v0 = valid_cnt;
      for (int i = 0; i < 12; i++) tick(i[0] ? 16'h0000 : 16'hFFFF);
      check_eq("h0_locked", 32'(locked), 32'd1);
      check_eq("h0_hp", 32'(half_period), 32'd0);
      check_eq("h0_vol", 32'(volume), 32'hFFFF);
      check_eq("h0_pulses", 32'(valid_cnt - v0), 32'd8);

      // Asynchronous reset clears without a clock edge
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_locked", 32'(locked), 32'd0);
      check_eq("async_rst_vol", 32'(volume), 32'd0);
      tick(16'h0000);
      reset_n = 1'b1;

      // Relock at H=3, then hold the input low
      phase(16'h0000, 3);
      phase(16'h4000, 4);
      phase(16'h0000, 4);
      phase(16'h4000, 4);
      check_eq("hold_pre_locked", 32'(locked), 32'd1);
      phase(16'h0000, 103);
`ifdef SQUARE_DECODE_TIMEOUT_EN
      check_eq("to_early", 32'(timeout), 32'd0);
      tick(16'h0000);
      check_eq("to_set", 32'(timeout), 32'd1);
      check_eq("to_locked", 32'(locked), 32'd0);
      check_eq("to_hp", 32'(half_period), 32'd0);
      check_eq("to_vol", 32'(volume), 32'd0);
      phase(16'h4000, 3);
      check_eq("to_clear", 32'(timeout), 32'd0);
`else
      phase(16'h0000, 50);
      check_eq("hold_timeout", 32'(timeout), 32'd0);
      check_eq("hold_locked", 32'(locked), 32'd1);
      check_eq("hold_hp", 32'(half_period), 32'd3);
      check_eq("hold_vol", 32'(volume), 32'h4000);
`endif

      check_eq("valid_only_locked", 32'(bad_valid), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
